// File: rtl/vec_exec_pkg.sv
// vec_exec_pkg: shared constants and helpers for the vector execute stage.
//   - default lane geometry (LANE_W x LANES) and scalar width
//   - opcode encodings, including the NOP/bubble opcode
//   - FSM state constants (IDLE / MUL)
//   - lane-ALU operation selects
//   - opcode classification helpers
package vec_exec_pkg;

   localparam int unsigned LANE_W_DEF   = 8;
   localparam int unsigned LANES_DEF    = 8;
   localparam int unsigned SCALAR_W_DEF = 32;

   localparam logic [4:0] OP_SADD  = 5'b00000;
   localparam logic [4:0] OP_SSUB  = 5'b00001;
   localparam logic [4:0] OP_SADDI = 5'b00010;
   localparam logic [4:0] OP_VADD  = 5'b00100;
   localparam logic [4:0] OP_VSUB  = 5'b00101;
   localparam logic [4:0] OP_VMUL  = 5'b01000;
   localparam logic [4:0] OP_VMULS = 5'b01001;
   localparam logic [4:0] OP_VSHL  = 5'b01010;
   localparam logic [4:0] OP_VXOR  = 5'b01011;
   localparam logic [4:0] OP_NOP   = 5'b11110;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   localparam logic [2:0] LOP_ADD = 3'd0;
   localparam logic [2:0] LOP_SUB = 3'd1;
   localparam logic [2:0] LOP_XOR = 3'd2;
   localparam logic [2:0] LOP_SHL = 3'd3;
   localparam logic [2:0] LOP_MUL = 3'd4;

   // Results of 001xx and 01xxx target the vector register file.
   function automatic logic is_vector_op(input logic [4:0] op);
      return (op[4:2] == 3'b001) || (op[4:3] == 2'b01);
   endfunction

   function automatic logic is_mul_op(input logic [4:0] op);
      return (op == OP_VMUL) || (op == OP_VMULS);
   endfunction

   // Opcodes that produce a result; everything else behaves as a bubble.
   function automatic logic is_defined_op(input logic [4:0] op);
      logic r;
      case (op)
         OP_SADD, OP_SSUB, OP_SADDI, OP_VADD, OP_VSUB,
         OP_VMUL, OP_VMULS, OP_VSHL, OP_VXOR: r = 1'b1;
         default:                             r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/vec_execute_stage_if.sv
// vec_execute_stage_if: decode/execute register to execute stage bus.
//   master (upstream/decode side): drives flush, opcode, operands and wb_register;
//                                  receives stall and the registered result.
//   slave  (execute stage):        the reverse.
//   stall high = master must hold every input stable.
interface vec_execute_stage_if import vec_exec_pkg::*; #(
   parameter int unsigned LANE_W   = LANE_W_DEF,
   parameter int unsigned LANES    = LANES_DEF,
   parameter int unsigned SCALAR_W = SCALAR_W_DEF
) ();

   localparam int unsigned VEC_W = LANES * LANE_W;

   logic                flush;
   logic [4:0]          opcode;
   logic [SCALAR_W-1:0] reg1_data;
   logic [SCALAR_W-1:0] reg2_data;
   logic [7:0]          immediate;
   logic [VEC_W-1:0]    vec1_data;
   logic [VEC_W-1:0]    vec2_data;
   logic [2:0]          wb_register;

   logic                stall;
   logic                out_valid;
   logic                out_is_vector;
   logic [4:0]          out_opcode;
   logic [SCALAR_W-1:0] out_scalar;
   logic [VEC_W-1:0]    out_vector;
   logic [2:0]          out_wb_register;

   modport master (
      output flush, opcode, reg1_data, reg2_data, immediate, vec1_data, vec2_data, wb_register,
      input  stall, out_valid, out_is_vector, out_opcode, out_scalar, out_vector,
             out_wb_register
   );

   modport slave (
      input  flush, opcode, reg1_data, reg2_data, immediate, vec1_data, vec2_data, wb_register,
      output stall, out_valid, out_is_vector, out_opcode, out_scalar, out_vector,
             out_wb_register
   );

endinterface

// File: rtl/vec_lane_alu.sv
// vec_lane_alu: combinational single-lane operation.
//   i_op     lane operation select (LOP_ADD/SUB/XOR/SHL/MUL)
//   i_a      lane operand A
//   i_b      lane operand B
//   i_shamt  left shift amount for LOP_SHL (zero fill)
//   o_res    lane result
// Build option VEC_EXEC_SAT_EN: add, sub and mul clamp unsigned to [0, 2^LANE_W-1];
// without it every result wraps modulo 2^LANE_W.
module vec_lane_alu import vec_exec_pkg::*; #(
   parameter int unsigned LANE_W = LANE_W_DEF
) (
   input  logic [2:0]        i_op,
   input  logic [LANE_W-1:0] i_a,
   input  logic [LANE_W-1:0] i_b,
   input  logic [2:0]        i_shamt,
   output logic [LANE_W-1:0] o_res
);

`ifdef VEC_EXEC_SAT_EN
   logic [LANE_W:0]     w_sum;
   logic [2*LANE_W-1:0] w_prod;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_prod = {{LANE_W{1'b0}}, i_a} * {{LANE_W{1'b0}}, i_b};
`endif

   always_comb begin
      o_res = '0;
      case (i_op)
`ifdef VEC_EXEC_SAT_EN
         LOP_ADD: o_res = w_sum[LANE_W] ? '1 : w_sum[LANE_W-1:0];
         LOP_SUB: o_res = (i_a < i_b) ? '0 : (i_a - i_b);
         LOP_MUL: o_res = (|w_prod[2*LANE_W-1:LANE_W]) ? '1 : w_prod[LANE_W-1:0];
`else
         LOP_ADD: o_res = i_a + i_b;
         LOP_SUB: o_res = i_a - i_b;
         LOP_MUL: o_res = i_a * i_b;
`endif
         LOP_XOR: o_res = i_a ^ i_b;
         LOP_SHL: o_res = i_a << i_shamt;
         default: o_res = '0;
      endcase
   end

endmodule

// File: rtl/vec_execute_stage.sv
// vec_execute_stage: execute stage of the vector CPU.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    vec_execute_stage_if.slave: decoded instruction in, stall and registered result out
// Scalar and non-multiply vector ops complete in one cycle. VMUL/VMULS run one lane per
// cycle through a single shared lane ALU while stall holds the upstream register; the
// held instruction is consumed on the edge that computes the last lane.
// Build option VEC_EXEC_SAT_EN: unsigned per-lane saturation for VADD/VSUB/VMUL/VMULS.
module vec_execute_stage import vec_exec_pkg::*; #(
   parameter int unsigned LANE_W   = LANE_W_DEF,
   parameter int unsigned LANES    = LANES_DEF,
   parameter int unsigned SCALAR_W = SCALAR_W_DEF
) (
   input logic                clk,
   input logic                reset,
   vec_execute_stage_if.slave bus
);

   localparam int unsigned     VEC_W     = LANES * LANE_W;
   localparam int unsigned     CNT_W     = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   logic [0:0]          r_state;
   logic [CNT_W-1:0]    r_lane_cnt;
   logic [VEC_W-1:0]    r_vec1;
   logic [VEC_W-1:0]    r_vec2;
   logic [VEC_W-1:0]    r_acc;
   logic [4:0]          r_opcode;
   logic [2:0]          r_wb;

   logic                r_out_valid;
   logic                r_out_is_vector;
   logic [4:0]          r_out_opcode;
   logic [SCALAR_W-1:0] r_out_scalar;
   logic [VEC_W-1:0]    r_out_vector;
   logic [2:0]          r_out_wb;

   logic                w_stall;
   logic [2:0]          w_par_op;
   logic [VEC_W-1:0]    w_par_res;
   logic [SCALAR_W-1:0] w_scalar;
   logic [LANE_W-1:0]   w_mul_a;
   logic [LANE_W-1:0]   w_mul_b;
   logic [LANE_W-1:0]   w_mul_res;
   logic [VEC_W-1:0]    w_acc_next;

   // ---------------- single-cycle datapath ----------------
   always_comb begin
      w_par_op = LOP_ADD;
      case (bus.opcode)
         OP_VSUB: w_par_op = LOP_SUB;
         OP_VXOR: w_par_op = LOP_XOR;
         OP_VSHL: w_par_op = LOP_SHL;
         default: w_par_op = LOP_ADD;
      endcase
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      vec_lane_alu #(
         .LANE_W (LANE_W)
      ) u_lane (
         .i_op    (w_par_op),
         .i_a     (bus.vec1_data[g*LANE_W +: LANE_W]),
         .i_b     (bus.vec2_data[g*LANE_W +: LANE_W]),
         .i_shamt (bus.immediate[2:0]),
         .o_res   (w_par_res[g*LANE_W +: LANE_W])
      );
   end

   always_comb begin
      w_scalar = '0;
      case (bus.opcode)
         OP_SADD:  w_scalar = bus.reg1_data + bus.reg2_data;
         OP_SSUB:  w_scalar = bus.reg1_data - bus.reg2_data;
         OP_SADDI: w_scalar = bus.reg1_data + {{(SCALAR_W-8){1'b0}}, bus.immediate};
         default:  w_scalar = '0;
      endcase
   end

   // ---------------- lane-serial multiply ----------------
   always_comb begin
      w_mul_a = '0;
      w_mul_b = '0;
      for (int i = 0; i < LANES; i++) begin
         if (r_lane_cnt == CNT_W'(i)) begin
            w_mul_a = r_vec1[i*LANE_W +: LANE_W];
            w_mul_b = r_vec2[i*LANE_W +: LANE_W];
         end
      end
   end

   vec_lane_alu #(
      .LANE_W (LANE_W)
   ) u_mul_lane (
      .i_op    (LOP_MUL),
      .i_a     (w_mul_a),
      .i_b     (w_mul_b),
      .i_shamt (3'd0),
      .o_res   (w_mul_res)
   );

   // Accumulator with the current lane merged in; on the last lane this is the full result.
   always_comb begin
      w_acc_next = r_acc;
      for (int i = 0; i < LANES; i++) begin
         if (r_lane_cnt == CNT_W'(i)) begin
            w_acc_next[i*LANE_W +: LANE_W] = w_mul_res;
         end
      end
   end

   // ---------------- stall ----------------
   always_comb begin
      w_stall = 1'b0;
      if (reset) begin
         if (r_state == ST_IDLE) begin
            w_stall = is_mul_op(bus.opcode);
         end else begin
            w_stall = (r_lane_cnt != LAST_LANE);
         end
      end
   end

   // ---------------- state and result registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= ST_IDLE;
         r_lane_cnt      <= '0;
         r_vec1          <= '0;
         r_vec2          <= '0;
         r_acc           <= '0;
         r_opcode        <= OP_NOP;
         r_wb            <= '0;
         r_out_valid     <= 1'b0;
         r_out_is_vector <= 1'b0;
         r_out_opcode    <= OP_NOP;
         r_out_scalar    <= '0;
         r_out_vector    <= '0;
         r_out_wb        <= '0;
      end else if (bus.flush) begin
         // Abort wins over any start or completion; the partial accumulator is dropped.
         r_state     <= ST_IDLE;
         r_lane_cnt  <= '0;
         r_out_valid <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         if (is_mul_op(bus.opcode)) begin
            r_state     <= ST_MUL;
            r_lane_cnt  <= '0;
            r_acc       <= '0;
            r_vec1      <= bus.vec1_data;
            // VMULS: broadcast the scalar's low lane so both forms share one datapath.
            r_vec2      <= (bus.opcode == OP_VMULS) ? {LANES{bus.reg1_data[LANE_W-1:0]}}
                                                    : bus.vec2_data;
            r_opcode    <= bus.opcode;
            r_wb        <= bus.wb_register;
            r_out_valid <= 1'b0;
         end else if (is_defined_op(bus.opcode)) begin
            r_out_valid     <= 1'b1;
            r_out_is_vector <= is_vector_op(bus.opcode);
            r_out_opcode    <= bus.opcode;
            r_out_wb        <= bus.wb_register;
            if (is_vector_op(bus.opcode)) begin
               r_out_vector <= w_par_res;
            end else begin
               r_out_scalar <= w_scalar;
            end
         end else begin
            r_out_valid <= 1'b0;
         end
      end else begin
         r_acc <= w_acc_next;
         if (r_lane_cnt == LAST_LANE) begin
            r_state         <= ST_IDLE;
            r_lane_cnt      <= '0;
            r_out_valid     <= 1'b1;
            r_out_is_vector <= 1'b1;
            r_out_opcode    <= r_opcode;
            r_out_wb        <= r_wb;
            r_out_vector    <= w_acc_next;
         end else begin
            r_lane_cnt  <= r_lane_cnt + CNT_W'(1);
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.stall           = w_stall;
   assign bus.out_valid       = r_out_valid;
   assign bus.out_is_vector   = r_out_is_vector;
   assign bus.out_opcode      = r_out_opcode;
   assign bus.out_scalar      = r_out_scalar;
   assign bus.out_vector      = r_out_vector;
   assign bus.out_wb_register = r_out_wb;

endmodule

// File: tb/tb_vec_execute_stage.sv
// tb_vec_execute_stage: scoreboard bench for vec_execute_stage.
// The driver issues instructions and, on the consuming edge, pushes the reference-model
// result; an independent monitor pops and compares whenever out_valid is seen.
// Honours VEC_EXEC_SAT_EN so the model matches the selected build.
module tb_vec_execute_stage;

   localparam logic [4:0] SADD  = 5'b00000;
   localparam logic [4:0] SSUB  = 5'b00001;
   localparam logic [4:0] SADDI = 5'b00010;
   localparam logic [4:0] VADD  = 5'b00100;
   localparam logic [4:0] VSUB  = 5'b00101;
   localparam logic [4:0] VMUL  = 5'b01000;
   localparam logic [4:0] VMULS = 5'b01001;
   localparam logic [4:0] VSHL  = 5'b01010;
   localparam logic [4:0] VXOR  = 5'b01011;
   localparam logic [4:0] NOP   = 5'b11110;

`ifdef VEC_EXEC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic        is_vec;
      logic [4:0]  op;
      logic [31:0] sc;
      logic [63:0] vec;
      logic [2:0]  wb;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vec_execute_stage_if #(.LANE_W(8), .LANES(8), .SCALAR_W(32)) bus ();

   vec_execute_stage #(
      .LANE_W   (8),
      .LANES    (8),
      .SCALAR_W (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%0h req=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic defined_op(input logic [4:0] op);
      return op inside {SADD, SSUB, SADDI, VADD, VSUB, VMUL, VMULS, VSHL, VXOR};
   endfunction

   // Reference: lane values as plain integers, then wrapped or clamped to 0..255.
   function automatic exp_t model(input logic [4:0] op, input logic [31:0] r1,
                                  input logic [31:0] r2, input logic [7:0] imm,
                                  input logic [63:0] v1, input logic [63:0] v2,
                                  input logic [2:0] wb);
      exp_t e;
      int   a, b, s;
      e.op     = op;
      e.wb     = wb;
      e.sc     = '0;
      e.vec    = '0;
      e.due    = 0;
      e.is_vec = !(op inside {SADD, SSUB, SADDI});
      case (op)
         SADD:  e.sc = r1 + r2;
         SSUB:  e.sc = r1 - r2;
         SADDI: e.sc = r1 + {24'd0, imm};
         default: begin
            for (int i = 0; i < 8; i++) begin
               a = int'(v1[8*i +: 8]);
               b = (op == VMULS) ? int'(r1[7:0]) : int'(v2[8*i +: 8]);
               s = 0;
               case (op)
                  VADD: begin s = a + b; if (SAT && s > 255) s = 255; end
                  VSUB: begin s = a - b; if (SAT && s < 0) s = 0; end
                  VMUL, VMULS: begin s = a * b; if (SAT && s > 255) s = 255; end
                  VXOR: s = a ^ b;
                  VSHL: s = a << (imm % 8);
                  default: s = 0;
               endcase
               e.vec[8*i +: 8] = s[7:0];
            end
         end
      endcase
      return e;
   endfunction

   // Monitor: every valid result must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b1 && bus.out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid act=1 req=0 op=%b (t=%0t)", bus.out_opcode, $time);
         end else begin
            e = sb.pop_front();
            check("latency", 64'(cyc), 64'(e.due));
            check("out_is_vector", 64'(bus.out_is_vector), 64'(e.is_vec));
            check("out_opcode", 64'(bus.out_opcode), 64'(e.op));
            check("out_wb_register", 64'(bus.out_wb_register), 64'(e.wb));
            if (e.is_vec) check("out_vector", bus.out_vector, e.vec);
            else          check("out_scalar", 64'(bus.out_scalar), 64'(e.sc));
         end
      end
   end

   // Drive one instruction (called just after a rising edge) and wait for its consumption.
   task automatic issue(input logic [4:0] op, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [7:0] imm, input logic [63:0] v1, input logic [63:0] v2,
                        input logic [2:0] wb);
      exp_t e;
      int   ns;
      int   c;
      logic s;
      bit   done;
      bus.opcode      = op;
      bus.reg1_data   = r1;
      bus.reg2_data   = r2;
      bus.immediate   = imm;
      bus.vec1_data   = v1;
      bus.vec2_data   = v2;
      bus.wb_register = wb;
      e    = model(op, r1, r2, imm, v1, v2, wb);
      ns   = 0;
      c    = 0;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         s = bus.stall;
         c = cyc;
         @(posedge clk);
         if (s === 1'b0) done = 1'b1;
         else            ns++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL consume_timeout act=stalled req=consumed op=%b", op);
      end else begin
         if (defined_op(op)) begin
            e.due = c + 1;
            sb.push_back(e);
         end
         check("stall_cycles", 64'(ns), (op == VMUL || op == VMULS) ? 64'd8 : 64'd0);
      end
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_stall"}, 64'(bus.stall), 64'd0);
      check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_is_vector"}, 64'(bus.out_is_vector), 64'd0);
      check({tag, "_opcode"}, 64'(bus.out_opcode), 64'(NOP));
      check({tag, "_scalar"}, 64'(bus.out_scalar), 64'd0);
      check({tag, "_vector"}, bus.out_vector, 64'd0);
      check({tag, "_wb"}, 64'(bus.out_wb_register), 64'd0);
   endtask

   function automatic logic [4:0] rand_op();
      logic [4:0] op;
      case ($urandom_range(0, 11))
         0:  op = SADD;
         1:  op = SSUB;
         2:  op = SADDI;
         3:  op = VADD;
         4:  op = VSUB;
         5:  op = VMUL;
         6:  op = VMULS;
         7:  op = VSHL;
         8:  op = VXOR;
         9:  op = NOP;
         10: op = 5'b01100;
         default: op = 5'b10101;
      endcase
      return op;
   endfunction

   task automatic set_vmul();
      bus.opcode      = VMUL;
      bus.vec1_data   = 64'h0303_0303_0303_0303;
      bus.vec2_data   = 64'h0505_0505_0505_0505;
      bus.wb_register = 3'd6;
   endtask

   initial begin
      reset           = 1'b0;
      bus.flush       = 1'b0;
      bus.opcode      = VMUL;
      bus.reg1_data   = '0;
      bus.reg2_data   = '0;
      bus.immediate   = '0;
      bus.vec1_data   = '0;
      bus.vec2_data   = '0;
      bus.wb_register = '0;

      // Reset holds stall low even with a multiply presented.
      #12;
      check_reset_outputs("reset");
      bus.opcode = NOP;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases.
      issue(SADD, 32'hFFFF_FFFF, 32'd1, 8'h00, '0, '0, 3'd1);
      issue(VADD, 32'd0, 32'd0, 8'h00, 64'h01FF_0000_0000_00F0, 64'h0101_0000_0000_0020, 3'd2);
      issue(VMUL, 32'd0, 32'd0, 8'h00, 64'h0303_0303_0303_0303, 64'h0505_0505_0505_0505, 3'd3);
      issue(SSUB, 32'd5, 32'd7, 8'h00, '0, '0, 3'd4);
      issue(VMULS, 32'h0000_0002, 32'd0, 8'h00, 64'h0102_0304_0506_0708, '0, 3'd5);
      issue(VSUB, 32'd0, 32'd0, 8'h00, 64'h0010_2000_FF00_0105, 64'h0020_1001_0100_0203, 3'd6);
      issue(VSHL, 32'd0, 32'd0, 8'hFB, 64'h8001_FF7F_0102_0408, '0, 3'd7);
      issue(SADDI, 32'h0000_00F0, 32'd0, 8'hFF, '0, '0, 3'd0);
      issue(NOP, 32'd1, 32'd2, 8'h00, '0, '0, 3'd1);

      // Randomised instruction stream.
      for (int n = 0; n < 250; n++) begin
         issue(rand_op(), $urandom, $urandom, 8'($urandom), {$urandom, $urandom},
               {$urandom, $urandom}, 3'($urandom));
      end

      // Flush after lanes 0..3 are done (lane_cnt == 4): result dropped, stage idle.
      set_vmul();
      repeat (5) @(posedge clk);
      #1;
      bus.flush  = 1'b1;
      bus.opcode = NOP;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("flush_stall", 64'(bus.stall), 64'd0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("flush_no_valid", 64'(bus.out_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      issue(SADD, 32'd100, 32'd23, 8'h00, '0, '0, 3'd2);
      issue(VXOR, 32'd0, 32'd0, 8'h00, 64'hFFFF_0000_AAAA_5555, 64'h0F0F_F0F0_5555_5555, 3'd3);

      // Asynchronous reset while lane 3 is in progress.
      set_vmul();
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("midmul_reset");
      bus.opcode = NOP;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("post_reset_no_valid", 64'(bus.out_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      issue(VMULS, 32'h0000_0011, 32'd0, 8'h00, 64'h0102_0304_0506_0F10, '0, 3'd4);
      issue(SSUB, 32'd0, 32'd1, 8'h00, '0, '0, 3'd5);
      bus.opcode = NOP;

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
